// File: rtl/conv_stream_param.sv
// Streaming 1-D convolution: F_SIZE taps loaded once, X_SIZE samples slid through a product/adder-tree pipeline.
// Latency: result valid LOG2F+2 edges after the sample completing its window; one result per cycle sustained.
// Backpressure: a held output freezes every stage (en) and drops s_ready_x in the same cycle.
module conv_stream_param #(
  parameter int X_W    = 8,
  parameter int F_W    = 8,
  parameter int X_SIZE = 128,
  parameter int F_SIZE = 32,
  parameter int OUT_W  = 21,
  parameter int LOG2F  = $clog2(F_SIZE),
  parameter int ACC_W  = X_W + F_W + LOG2F
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             s_valid_x,
  output logic             s_ready_x,
  input  logic [X_W-1:0]   s_data_in_x,
  input  logic             s_valid_f,
  output logic             s_ready_f,
  input  logic [F_W-1:0]   s_data_in_f,
  input  logic             cfg_relu,
  input  logic             cfg_keep_f,
  output logic             m_valid_y,
  input  logic             m_ready_y,
  output logic [OUT_W-1:0] m_data_out_y,
  output logic             m_last_y,
  output logic             done
);

  localparam int XCW = $clog2(X_SIZE + 1);
  localparam int FCW = $clog2(F_SIZE);

  typedef enum logic [1:0] {LOAD_F, RUN, DRAIN} state_t;
  state_t state, state_nx;

  logic signed [F_W-1:0]   f       [F_SIZE];
  logic signed [X_W-1:0]   win     [F_SIZE];
  logic signed [X_W-1:0]   win_sh  [F_SIZE];
  // Heap-ordered adder tree: leaves at F_SIZE..2*F_SIZE-1 hold products, node i sums 2i and 2i+1.
  // Registering every node each enabled cycle makes each tree level one pipeline stage.
  logic signed [ACC_W-1:0] node_q  [1:2*F_SIZE-1];
  logic signed [ACC_W-1:0] node_d  [1:2*F_SIZE-1];
  logic signed [ACC_W-1:0] acc_r;
  logic signed [OUT_W-1:0] y_nx;

  logic [FCW-1:0] f_cnt;
  logic [XCW-1:0] x_cnt;
  logic           relu_q;
  logic           win_vld, win_last;
  logic [LOG2F:0] vld_p, last_p;

  logic en, f_acc, x_acc, last_acc, go_run, go_load;

  assign en       = !m_valid_y || m_ready_y;
  assign f_acc    = s_valid_f && s_ready_f;
  assign x_acc    = s_valid_x && s_ready_x;
  assign last_acc = m_valid_y && m_ready_y && m_last_y;
  assign go_run   = (state == LOAD_F && f_acc && f_cnt == FCW'(F_SIZE - 1)) ||
                    (state == DRAIN && last_acc && cfg_keep_f);
  assign go_load  = (state == DRAIN) && last_acc && !cfg_keep_f;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= LOAD_F;
    else       state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      LOAD_F: if (f_acc && f_cnt == FCW'(F_SIZE - 1)) state_nx = RUN;
      RUN:    if (x_acc && x_cnt == XCW'(X_SIZE - 1)) state_nx = DRAIN;
      DRAIN:  if (last_acc) state_nx = cfg_keep_f ? RUN : LOAD_F;
      default: state_nx = LOAD_F;
    endcase
  end

  // Outputs decoded from state; readies are held low while reset is asserted
  always_comb begin
    s_ready_f = 1'b0;
    s_ready_x = 1'b0;
    done      = 1'b0;
    unique case (state)
      LOAD_F: s_ready_f = !reset;
      RUN:    s_ready_x = !reset && en && (x_cnt < XCW'(X_SIZE));
      DRAIN:  done      = last_acc;
      default: ;
    endcase
  end

  // Coefficient store, sample window and counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      f      <= '{default: '0};
      win    <= '{default: '0};
      f_cnt  <= '0;
      x_cnt  <= '0;
      relu_q <= 1'b0;
    end else begin
      if (f_acc) begin
        f[f_cnt] <= s_data_in_f;
        f_cnt    <= f_cnt + 1'b1;
      end
      if (go_load) f_cnt <= '0;
      if (go_run) begin
        x_cnt  <= '0;
        win    <= '{default: '0};
        relu_q <= cfg_relu;
      end else if (x_acc) begin
        win   <= win_sh;
        x_cnt <= x_cnt + 1'b1;
      end
    end
  end

  // Window shifts toward tap 0 so that win[k] pairs with f[k]; products form the tree leaves
  for (genvar k = 0; k < F_SIZE; k++) begin : g_tap
    logic signed [X_W+F_W-1:0] prod;
    if (k == F_SIZE - 1) begin : g_top
      assign win_sh[k] = s_data_in_x;
    end else begin : g_mid
      assign win_sh[k] = win[k+1];
    end
    assign prod = $signed({{F_W{win[k][X_W-1]}}, win[k]}) *
                  $signed({{X_W{f[k][F_W-1]}}, f[k]});
    assign node_d[F_SIZE+k] = {{LOG2F{prod[X_W+F_W-1]}}, prod};
  end

  for (genvar i = 1; i < F_SIZE; i++) begin : g_add
    assign node_d[i] = node_q[2*i] + node_q[2*i+1];
  end

  assign acc_r = (relu_q && node_q[1][ACC_W-1]) ? '0 : node_q[1];

  if (OUT_W < ACC_W) begin : g_sat
    localparam logic signed [ACC_W-1:0] MAXV = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] MINV = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
    // Clamp the full-precision sum into the narrower output range
    always_comb begin
      if (acc_r > MAXV)      y_nx = MAXV[OUT_W-1:0];
      else if (acc_r < MINV) y_nx = MINV[OUT_W-1:0];
      else                   y_nx = acc_r[OUT_W-1:0];
    end
  end else if (OUT_W == ACC_W) begin : g_eq
    assign y_nx = acc_r;
  end else begin : g_ext
    assign y_nx = {{(OUT_W-ACC_W){acc_r[ACC_W-1]}}, acc_r};
  end

  // Pipeline stages, valid/last tags and output register, all advancing together on en
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      win_vld      <= 1'b0;
      win_last     <= 1'b0;
      vld_p        <= '0;
      last_p       <= '0;
      node_q       <= '{default: '0};
      m_valid_y    <= 1'b0;
      m_last_y     <= 1'b0;
      m_data_out_y <= '0;
    end else if (en) begin
      win_vld      <= x_acc && (x_cnt >= XCW'(F_SIZE - 1));
      win_last     <= x_acc && (x_cnt == XCW'(X_SIZE - 1));
      vld_p        <= {vld_p[LOG2F-1:0], win_vld};
      last_p       <= {last_p[LOG2F-1:0], win_last};
      node_q       <= node_d;
      m_valid_y    <= vld_p[LOG2F];
      m_last_y     <= last_p[LOG2F];
      m_data_out_y <= y_nx;
    end
  end

endmodule

// File: tb/tb_conv_stream_param.sv
// Bench for conv_stream_param: a small 4-tap/8-sample instance for function, stall, ReLU,
// retention and reset, plus a default-size 16-bit-output instance for saturation.
module tb_conv_stream_param;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Small instance
  logic sv_xa = 0, sr_xa, sv_fa = 0, sr_fa, relu_a = 0, keep_a = 0;
  logic mv_a, mr_a = 1, ml_a, done_a;
  logic [7:0]  sx_a = 0, sf_a = 0;
  logic [20:0] my_a;

  conv_stream_param #(.X_W(8), .F_W(8), .X_SIZE(8), .F_SIZE(4), .OUT_W(21)) dut_a (
    .clk(clk), .reset(rst),
    .s_valid_x(sv_xa), .s_ready_x(sr_xa), .s_data_in_x(sx_a),
    .s_valid_f(sv_fa), .s_ready_f(sr_fa), .s_data_in_f(sf_a),
    .cfg_relu(relu_a), .cfg_keep_f(keep_a),
    .m_valid_y(mv_a), .m_ready_y(mr_a), .m_data_out_y(my_a), .m_last_y(ml_a),
    .done(done_a));

  // Default-size instance with narrow output
  logic sv_xb = 0, sr_xb, sv_fb = 0, sr_fb, relu_b = 0, keep_b = 0;
  logic mv_b, mr_b = 1, ml_b, done_b;
  logic [7:0]  sx_b = 0, sf_b = 0;
  logic [15:0] my_b;

  conv_stream_param #(.OUT_W(16)) dut_b (
    .clk(clk), .reset(rst),
    .s_valid_x(sv_xb), .s_ready_x(sr_xb), .s_data_in_x(sx_b),
    .s_valid_f(sv_fb), .s_ready_f(sr_fb), .s_data_in_f(sf_b),
    .cfg_relu(relu_b), .cfg_keep_f(keep_b),
    .m_valid_y(mv_b), .m_ready_y(mr_b), .m_data_out_y(my_b), .m_last_y(ml_b),
    .done(done_b));

  int fa[4], xa[8], fb[32], xb[128];

  // Observation of accepted outputs and done pulses
  int got_a[$];  bit lst_a[$];  int xacc_a[$];
  int got_b[$];  bit lst_b[$];
  int done_cnt_a = 0, done_bad_a = 0, done_cnt_b = 0;
  int first_v_a = -1;
  bit mv_prev_a = 0;

  always @(negedge clk) begin
    if (mv_a && mr_a) begin got_a.push_back(int'($signed(my_a))); lst_a.push_back(ml_a); end
    if (done_a) begin
      done_cnt_a++;
      if (!(mv_a && mr_a && ml_a)) done_bad_a++;
    end
    if (sv_xa && sr_xa) xacc_a.push_back(cyc + 1);
    if (mv_a && !mv_prev_a && first_v_a < 0) first_v_a = cyc;
    mv_prev_a = mv_a;
    if (mv_b && mr_b) begin got_b.push_back(int'($signed(my_b))); lst_b.push_back(ml_b); end
    if (done_b) done_cnt_b++;
  end

  // Reference model: direct convolution sum, then ReLU, then clamp to the output width
  function automatic longint clamp(input longint s, input int w);
    longint hi, lo;
    hi = (longint'(1) << (w - 1)) - 1;
    lo = -hi - 1;
    if (s > hi) return hi;
    if (s < lo) return lo;
    return s;
  endfunction

  function automatic int ref_a(input int n, input bit relu);
    longint s = 0;
    for (int k = 0; k < 4; k++) s += longint'(xa[n+k]) * fa[k];
    if (relu && s < 0) s = 0;
    return int'(clamp(s, 21));
  endfunction

  function automatic int ref_b(input int n, input bit relu);
    longint s = 0;
    for (int k = 0; k < 32; k++) s += longint'(xb[n+k]) * fb[k];
    if (relu && s < 0) s = 0;
    return int'(clamp(s, 16));
  endfunction

  task automatic push_a(input bit isf, input int v, input int gap, output bit ok);
    int t = 0;
    repeat (gap) begin @(posedge clk); #1; end
    if (isf) begin sv_fa = 1; sf_a = 8'(v); end
    else     begin sv_xa = 1; sx_a = 8'(v); end
    @(negedge clk);
    while (!(isf ? sr_fa : sr_xa) && t < 300) begin t++; @(negedge clk); end
    @(posedge clk); #1;
    if (isf) sv_fa = 0; else sv_xa = 0;
    ok = (t < 300);
  endtask

  task automatic push_b(input bit isf, input int v, output bit ok);
    int t = 0;
    if (isf) begin sv_fb = 1; sf_b = 8'(v); end
    else     begin sv_xb = 1; sx_b = 8'(v); end
    @(negedge clk);
    while (!(isf ? sr_fb : sr_xb) && t < 300) begin t++; @(negedge clk); end
    @(posedge clk); #1;
    if (isf) sv_fb = 0; else sv_xb = 0;
    ok = (t < 300);
  endtask

  task automatic load_a(input bit relu);
    bit ok;
    relu_a = relu;
    for (int k = 0; k < 4; k++) begin
      push_a(1'b1, fa[k], 0, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL load_a coef %0d: accepted=0 required=1", k); end
    end
  endtask

  // stall_mode: 0 always ready, 1 hold the output showing 40 for 5 cycles, 2 random ready
  task automatic run_a(input int stall_mode, input int gap_max);
    int base;
    got_a.delete(); lst_a.delete(); xacc_a.delete();
    first_v_a = -1; done_bad_a = 0; base = done_cnt_a;
    fork
      begin
        bit ok;
        for (int i = 0; i < 8; i++) begin
          push_a(1'b0, xa[i], $urandom_range(0, gap_max), ok);
          checks++;
          if (!ok) begin errors++; $display("FAIL run_a sample %0d: accepted=0 required=1", i); end
        end
      end
      begin
        int t = 0;
        bit stalled = 0;
        while (done_cnt_a == base && t < 1000) begin
          @(posedge clk); #1; t++;
          if (stall_mode == 2) mr_a = ($urandom_range(0, 9) < 7);
          else if (stall_mode == 1 && !stalled && mv_a && int'($signed(my_a)) == 40) begin
            mr_a = 0; stalled = 1;
            repeat (5) begin
              @(negedge clk);
              checks++;
              if (!(mv_a && int'($signed(my_a)) == 40)) begin
                errors++; $display("FAIL stall_hold: valid=%0b data=%0d required valid=1 data=40", mv_a, $signed(my_a));
              end
              checks++;
              if (sr_xa !== 1'b0) begin errors++; $display("FAIL stall_ready_x: got %b required 0", sr_xa); end
              @(posedge clk); #1;
            end
            mr_a = 1;
          end else mr_a = 1;
        end
        mr_a = 1;
        checks++;
        if (t >= 1000) begin errors++; $display("FAIL run_a done timeout: waited %0d cycles", t); end
      end
    join
  endtask

  task automatic check_a(input string name, input bit relu);
    int e;
    checks++;
    if (got_a.size() != 5) begin errors++; $display("FAIL %s count: got %0d required 5", name, got_a.size()); end
    for (int i = 0; i < 5 && i < got_a.size(); i++) begin
      e = ref_a(i, relu);
      checks++;
      if (got_a[i] !== e) begin errors++; $display("FAIL %s y[%0d]: got %0d required %0d", name, i, got_a[i], e); end
      checks++;
      if (lst_a[i] !== (i == 4)) begin errors++; $display("FAIL %s last[%0d]: got %0b required %0b", name, i, lst_a[i], i == 4); end
    end
    checks++;
    if (done_bad_a != 0) begin errors++; $display("FAIL %s done_align: stray pulses %0d required 0", name, done_bad_a); end
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({sr_xa, sr_fa, mv_a, ml_a, done_a} !== 5'b0 || my_a !== '0) begin
      errors++; $display("FAIL reset_a: rx=%b rf=%b v=%b l=%b d=%b y=%0d required all 0", sr_xa, sr_fa, mv_a, ml_a, done_a, my_a);
    end
    checks++;
    if ({sr_xb, sr_fb, mv_b, ml_b, done_b} !== 5'b0 || my_b !== '0) begin
      errors++; $display("FAIL reset_b: rx=%b rf=%b v=%b y=%0d required all 0", sr_xb, sr_fb, mv_b, my_b);
    end
    @(posedge clk); #1; rst = 0;
    @(negedge clk);
    checks++;
    if (sr_fa !== 1'b1 || sr_xa !== 1'b0) begin errors++; $display("FAIL reset_load_f: rf=%b rx=%b required 1 0", sr_fa, sr_xa); end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    fa = '{1, 2, 3, 4};
    for (int i = 0; i < 8; i++) xa[i] = i + 1;
    keep_a = 0;
    load_a(1'b0);
    run_a(0, 0);
    check_a("basic", 1'b0);
    checks++;
    if (xacc_a.size() < 4 || first_v_a - xacc_a[3] != 4) begin
      errors++; $display("FAIL basic_latency: got %0d edges required 4", xacc_a.size() < 4 ? -1 : first_v_a - xacc_a[3]);
    end
  endtask

  task automatic test_back_to_back();
    load_a(1'b0);
    run_a(1, 0);
    check_a("backpressure", 1'b0);
  endtask

  task automatic test_relu();
    fa = '{-1, -1, -1, -1};
    load_a(1'b0);
    run_a(0, 0);
    check_a("relu_off", 1'b0);
    load_a(1'b1);
    run_a(0, 0);
    check_a("relu_on", 1'b1);
  endtask

  task automatic test_keep();
    fa = '{1, 2, 3, 4};
    for (int i = 0; i < 8; i++) xa[i] = i + 1;
    load_a(1'b0);
    keep_a = 1;
    run_a(0, 0);
    check_a("keep_v1", 1'b0);
    @(negedge clk);
    checks++;
    if (sr_fa !== 1'b0) begin errors++; $display("FAIL keep_ready_f: got %b required 0", sr_fa); end
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) xa[i] = 20 - 3 * i;
    keep_a = 0;
    sv_fa = 1; sf_a = 8'd99;
    run_a(0, 0);
    sv_fa = 0;
    check_a("keep_v2", 1'b0);
    @(negedge clk);
    checks++;
    if (sr_fa !== 1'b1) begin errors++; $display("FAIL reload_ready_f: got %b required 1", sr_fa); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_run();
    bit ok;
    fa = '{1, 2, 3, 4};
    for (int i = 0; i < 8; i++) xa[i] = i + 1;
    load_a(1'b0);
    for (int i = 0; i < 5; i++) push_a(1'b0, xa[i], 0, ok);
    repeat (4) begin @(posedge clk); #1; end
    checks++;
    if (mv_a !== 1'b1) begin errors++; $display("FAIL midrun_valid: got %b required 1", mv_a); end
    rst = 1;
    #1;
    checks++;
    if (mv_a !== 1'b0 || my_a !== '0 || ml_a !== 1'b0 || sr_fa !== 1'b0 || sr_xa !== 1'b0) begin
      errors++; $display("FAIL midrun_reset: v=%b y=%0d l=%b rf=%b rx=%b required all 0", mv_a, my_a, ml_a, sr_fa, sr_xa);
    end
    @(posedge clk); #1; rst = 0;
    @(negedge clk);
    checks++;
    if (sr_fa !== 1'b1 || sr_xa !== 1'b0 || mv_a !== 1'b0) begin
      errors++; $display("FAIL midrun_state: rf=%b rx=%b v=%b required 1 0 0", sr_fa, sr_xa, mv_a);
    end
    @(posedge clk); #1;
    load_a(1'b0);
    run_a(0, 0);
    check_a("after_reset", 1'b0);
  endtask

  task automatic test_random();
    bit need_load = 1;
    bit cur_relu = 0;
    for (int it = 0; it < 8; it++) begin
      if (need_load) begin
        for (int k = 0; k < 4; k++) fa[k] = int'($urandom_range(0, 255)) - 128;
        load_a(1'(($urandom_range(0, 1))));
        cur_relu = relu_a;
      end
      for (int i = 0; i < 8; i++) xa[i] = int'($urandom_range(0, 255)) - 128;
      keep_a = 1'($urandom_range(0, 1));
      relu_a = 1'($urandom_range(0, 1));
      run_a(2, 2);
      check_a("random", cur_relu);
      need_load = !keep_a;
      cur_relu = relu_a;
    end
    if (!need_load) begin
      keep_a = 0;
      run_a(0, 0);
      check_a("random_tail", cur_relu);
    end
  endtask

  task automatic run_b(input string name);
    bit ok;
    int base, t, e;
    got_b.delete(); lst_b.delete();
    base = done_cnt_b; t = 0;
    for (int i = 0; i < 128; i++) begin
      push_b(1'b0, xb[i], ok);
      if (!ok) begin checks++; errors++; $display("FAIL %s sample %0d: accepted=0 required=1", name, i); break; end
    end
    while (done_cnt_b == base && t < 600) begin @(posedge clk); #1; t++; end
    checks++;
    if (t >= 600) begin errors++; $display("FAIL %s done timeout: waited %0d cycles", name, t); end
    checks++;
    if (got_b.size() != 97) begin errors++; $display("FAIL %s count: got %0d required 97", name, got_b.size()); end
    for (int i = 0; i < 97 && i < got_b.size(); i++) begin
      e = ref_b(i, 1'b0);
      checks++;
      if (got_b[i] !== e || lst_b[i] !== (i == 96)) begin
        errors++; $display("FAIL %s y[%0d]: got %0d last %0b required %0d last %0b", name, i, got_b[i], lst_b[i], e, i == 96);
      end
    end
  endtask

  task automatic test_saturation();
    bit ok;
    for (int k = 0; k < 32; k++) fb[k] = -128;
    relu_b = 0; keep_b = 1;
    for (int k = 0; k < 32; k++) begin
      push_b(1'b1, fb[k], ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL sat_load coef %0d: accepted=0 required=1", k); end
    end
    for (int i = 0; i < 128; i++) xb[i] = -128;
    run_b("sat_pos");
    @(negedge clk);
    checks++;
    if (sr_fb !== 1'b0) begin errors++; $display("FAIL sat_keep_ready_f: got %b required 0", sr_fb); end
    @(posedge clk); #1;
    keep_b = 0;
    for (int i = 0; i < 128; i++) xb[i] = 127;
    run_b("sat_neg");
    @(negedge clk);
    checks++;
    if (sr_fb !== 1'b1) begin errors++; $display("FAIL sat_reload_ready_f: got %b required 1", sr_fb); end
    @(posedge clk); #1;
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_relu();
    test_keep();
    test_reset_mid_run();
    test_random();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv_stream_param.md
Name: conv_stream_param

Overview:
Parametrised streaming 1-D convolution engine, successor to the fixed 128x32 convolution block. It loads F_SIZE filter coefficients, then streams an X_SIZE-sample vector through a sliding window with one multiplier per tap, a pipelined adder tree and an output register. Over the fixed block it adds a full-pipeline backpressure stall, optional filter retention across vectors, optional ReLU, output saturation, and last/done flags. It sits between the X and F AXI-stream sources and the Y consumer.

Parameters:
X_W, 8, signed sample width
F_W, 8, signed coefficient width
X_SIZE, 128, samples per vector; must be >= F_SIZE
F_SIZE, 32, taps; power of 2, >= 2
OUT_W, 21, signed output width
LOG2F, $clog2(F_SIZE), derived; adder-tree depth
ACC_W, X_W+F_W+LOG2F, derived; full-precision accumulator width

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
s_valid_x  in  1  sample valid
s_ready_x  out  1  sample ready
s_data_in_x  in  X_W  signed sample
s_valid_f  in  1  coefficient valid
s_ready_f  out  1  coefficient ready
s_data_in_f  in  F_W  signed coefficient
cfg_relu  in  1  clamp negative results to 0
cfg_keep_f  in  1  retain the filter for the next vector
m_valid_y  out  1  output valid
m_ready_y  in  1  output ready
m_data_out_y  out  OUT_W  signed result
m_last_y  out  1  marks the final output of a vector
done  out  1  one-cycle pulse when a vector is fully drained

Behaviour:
- Reset: one clock, asynchronous active-high reset. All registers clear, including coefficients, window, pipeline and valid bits. State goes to LOAD_F. Reset values: s_ready_x=0, s_ready_f=0, m_valid_y=0, m_data_out_y=0, m_last_y=0, done=0.
- Handshake: a transfer occurs on a rising edge where valid and ready are both 1. Data must hold while valid=1 and ready=0.
- Stall enable: en = !m_valid_y || m_ready_y. Every pipeline stage, valid bit and last bit advances only when en=1. A held output never changes.
- Output function: y[n] = sum over k=0..F_SIZE-1 of x[n+k]*f[k], for n = 0..X_SIZE-F_SIZE. That gives X_SIZE-F_SIZE+1 outputs per vector.
- LOAD_F state:
  - s_ready_f=1 and s_ready_x=0.
  - The k-th accepted coefficient is written to f[k]; a counter runs 0..F_SIZE-1.
  - After the F_SIZE-th accept: go to RUN, clear x_cnt, clear the window, latch cfg_relu into relu_q.
- RUN state:
  - s_ready_f=0. s_ready_x = en && (x_cnt < X_SIZE).
  - Each accepted sample shifts into the window and increments x_cnt.
  - A window-valid bit enters the pipeline when x_cnt >= F_SIZE-1 at accept. It carries last=1 when x_cnt == X_SIZE-1.
  - After the X_SIZE-th accept, go to DRAIN.
- DRAIN state:
  - s_ready_x=0 and s_ready_f=0.
  - When the output marked last is accepted (m_valid_y && m_ready_y && m_last_y), pulse done for 1 cycle.
  - In that same cycle, if cfg_keep_f=1: go to RUN with x_cnt cleared, window cleared and cfg_relu re-latched. Otherwise go to LOAD_F with the coefficient counter cleared; old coefficients are overwritten as they arrive.
- Pipeline stages, each gated by en:
  - stage P holds the F_SIZE registered products, each X_W+F_W wide and sign-extended to ACC_W;
  - LOG2F adder levels, pairwise and registered;
  - an output register applying ReLU then saturation.
- Latency: with en=1 throughout, m_valid_y rises LOG2F+2 edges after the edge that accepted x[n+F_SIZE-1] (7 for F_SIZE=32). Throughput is 1 output per cycle.
- Output arithmetic:
  - If relu_q and acc<0, the result is 0.
  - If OUT_W < ACC_W, saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - Otherwise sign-extend. No wrap-around is permitted.
- Boundary conditions:
  - s_valid_f is ignored outside LOAD_F.
  - s_valid_x is ignored outside RUN and once x_cnt == X_SIZE.
  - m_ready_y held low: the pipeline freezes and s_ready_x falls the same cycle through en. No sample or output is lost or duplicated.
  - The last output and done are never skipped under stall.
  - X_SIZE == F_SIZE gives exactly 1 output, with m_last_y=1.
  - Reset asserted mid-RUN or mid-DRAIN: the in-flight vector is discarded, and m_valid_y is low immediately (asynchronously).

Test Plan:
1. Basic convolution: F_SIZE=4, X_SIZE=8, f={1,2,3,4}, x=1..8, m_ready_y=1 -> outputs 30,40,50,60,70. First output valid 4 edges after x[3] is accepted. m_last_y=1 only on 70; done pulses once.
2. Backpressure: as test 1, m_ready_y=0 for 5 cycles once 40 is presented -> 40 held stable; s_ready_x=0 while stalled; full sequence 30..70 still delivered exactly once.
3. ReLU: f={-1,-1,-1,-1}, x=1..8. cfg_relu=0 -> -10,-14,-18,-22,-26. Reload filter with cfg_relu=1 -> 0,0,0,0,0.
4. Saturation: defaults with OUT_W=16, all f=-128.
   - all x=-128 -> acc 524288 -> output 32767 (all 97 outputs).
   - all x=127 -> output -32768.
5. Filter retention: cfg_keep_f=1 at end of vector 1, then vector 2 sent -> s_ready_f stays 0, vector 2 uses the old filter. With cfg_keep_f=0, s_ready_f=1 after done.
6. Reset mid-RUN: assert reset after 5 samples -> all outputs 0 and state LOAD_F. Then a full reload and vector reproduce test 1 exactly.
